uart_tx: RTL and testbench

Serial transmitter for the debug link. Converts the byte and start strobe that the debug unit issues (its `o_tx_data` / `o_tx_start`) into an 8N1 frame on the UART TX line, and returns the one-cycle `tx_done` pulse the debug unit waits on before sending the next byte. It has its own 16x-oversampling baud tick generator, so no external tick is needed.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/baud_rate_gen.sv | 38 +++
 rtl/uart_tx.sv | 140 ++++++++++++++
 tb/tb_uart_tx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, oversampling ratio and default link timing.
// Pure declarations; no clocked logic, no latency, no flow control.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam int OVERSAMPLE     = 16;
  localparam int DEFAULT_CLK_HZ = 50_000_000;
  localparam int DEFAULT_BAUD   = 19_200;

  // Nearest-integer divider: 50 MHz / (19200*16) lands on 163.
  function automatic int clks_per_tick(input int clk_hz, input int baud);
    return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
  endfunction

  localparam int DEFAULT_CLKS_PER_TICK = clks_per_tick(DEFAULT_CLK_HZ, DEFAULT_BAUD);

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/baud_rate_gen.sv
// Oversampling tick generator: one-cycle o_tick every CLKS_PER_TICK clocks while enabled.
// Tick is combinational off the divider; held at 0 when disabled or cleared, no backpressure.
module baud_rate_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = DEFAULT_CLKS_PER_TICK
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_tick
);

  localparam int            DW       = width_of(CLKS_PER_TICK);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_TICK - 1);

  logic [DW-1:0] div_q, div_d;

  always_comb begin
    div_d  = div_q;
    o_tick = 1'b0;
    if (i_clear || !i_enable) begin
      div_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d  = '0;
      o_tick = 1'b1;
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) div_q <= '0;
    else          div_q <= div_d;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1-style serial transmitter: accepts a byte while idle, shifts it out LSB first, pulses o_tx_done.
// Line goes low the cycle after acceptance; starts outside IDLE are dropped (no queueing).
module uart_tx
  import uart_pkg::*;
#(
  parameter int NB_DATA       = 8,
  parameter int SB_TICK       = 16,
  parameter int CLKS_PER_TICK = DEFAULT_CLKS_PER_TICK
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_tx_data,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic               o_busy
);

  localparam int            BW        = width_of(NB_DATA);
  localparam int            SW        = width_of(SB_TICK);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NB_DATA - 1);
  localparam logic [SW-1:0] LAST_STOP = SW'(SB_TICK - 1);
  localparam logic [3:0]    LAST_TICK = 4'(OVERSAMPLE - 1);

  tx_state_e          state_q, state_d;
  logic [3:0]         tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]      stop_cnt_q, stop_cnt_d;
  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic               armed_q, armed_d;
  logic               busy;
  logic               accept;
  logic               tick;

  assign busy = (state_q != ST_IDLE);
  // armed_q blocks a start that coincides with reset release.
  assign accept = !busy && armed_q && i_tx_start;

  baud_rate_gen #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_baud (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_enable(busy),
    .i_clear (accept),
    .o_tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    armed_d    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d    = ST_START;
          shreg_d    = i_tx_data;
          tick_cnt_d = '0;
          tx_d       = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            state_d    = ST_DATA;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            tx_d       = shreg_q[0];
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            shreg_d    = shreg_q >> 1;
            if (bit_cnt_q == LAST_BIT) begin
              state_d    = ST_STOP;
              stop_cnt_d = '0;
              tx_d       = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
              tx_d      = shreg_d[0];
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + SW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      armed_q    <= armed_d;
    end
  end

  assign o_tx      = tx_q;
  assign o_tx_done = done_q;
  assign o_busy    = busy;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at CLKS_PER_TICK=4 (bit = 64 cycles, frame = 640 cycles),
// plus a second instance with SB_TICK=32 for the long-stop-bit timing.
module tb_uart_tx;

  localparam int F = 640;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       tx, done, busy;
  logic       start32 = 1'b0;
  logic [7:0] data32  = 8'h00;
  logic       tx32, done32, busy32;

  uart_tx #(.NB_DATA(8), .SB_TICK(16), .CLKS_PER_TICK(4)) u_dut (
    .i_clock(clk), .i_reset(rst_n), .i_tx_start(start), .i_tx_data(data),
    .o_tx(tx), .o_tx_done(done), .o_busy(busy)
  );

  uart_tx #(.NB_DATA(8), .SB_TICK(32), .CLKS_PER_TICK(4)) u_dut32 (
    .i_clock(clk), .i_reset(rst_n), .i_tx_start(start32), .i_tx_data(data32),
    .o_tx(tx32), .o_tx_done(done32), .o_busy(busy32)
  );

  always #5 clk = ~clk;

  // cyc counts rising edges; values are sampled on falling edges, so a sample with
  // cyc==n lies in the cycle that ends at the edge the DUT calls "edge n".
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    int         s;
  } frame_t;

  frame_t exp_q[$];
  int     done_q[$];
  int     done_cnt = 0;

  // Reference receiver: finds the start-bit falling edge, samples at bit centres.
  logic       prev_tx = 1'b1;
  bit         rx_act  = 1'b0;
  int         rx_s    = 0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_sb   = 1'b0;
  always @(negedge clk) begin
    int off;
    int idx;
    frame_t f;
    if (!rst_n) begin
      rx_act  = 1'b0;
      prev_tx = 1'b1;
    end else begin
      if (!rx_act && prev_tx === 1'b1 && tx === 1'b0) begin
        rx_act = 1'b1;
        rx_s   = cyc;
      end else if (rx_act) begin
        off = cyc - rx_s;
        if (off >= 32 && ((off - 32) % 64) == 0) begin
          idx = (off - 32) / 64;
          if (idx == 0) rx_sb = tx;
          else if (idx <= 8) rx_byte[idx-1] = tx;
          else begin
            rx_act = 1'b0;
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_frame at cycle %0d: got byte 0x%0h, expected none", cyc, rx_byte);
            end else begin
              f = exp_q.pop_front();
              check("frame_data", {24'd0, rx_byte}, {24'd0, f.d});
              check("frame_start_cycle", rx_s, f.s);
              check("start_bit_level", {31'd0, rx_sb}, 32'd0);
              check("stop_bit_level", {31'd0, tx}, 32'd1);
            end
          end
        end
      end
      prev_tx = tx;
    end
  end

  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      done_cnt++;
      if (done_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done at cycle %0d: got pulse, expected none", cyc);
      end else begin
        check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy !== 1'b0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Issues a start at the current falling edge once idle; e is the acceptance cycle.
  task automatic send(input logic [7:0] d, output int e);
    frame_t f;
    wait_idle();
    start = 1'b1;
    data  = d;
    e     = cyc;
    f.d   = d;
    f.s   = e + 1;
    exp_q.push_back(f);
    done_q.push_back(e + 1 + F);
    @(negedge clk);
    start = 1'b0;
    data  = ~d;
  endtask

  initial begin
    int e;
    int e2;
    int d0;
    @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tx32", {31'd0, tx32}, 32'd1);
    check("rst_busy32", {31'd0, busy32}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5 with edge-accurate line/busy checks.
    send(8'hA5, e);
    check("a5_busy_first", {31'd0, busy}, 32'd1);
    check("a5_tx_first", {31'd0, tx}, 32'd0);
    at_cyc(e + 64);
    check("a5_start_last", {31'd0, tx}, 32'd0);
    at_cyc(e + 65);
    check("a5_bit0_first", {31'd0, tx}, 32'd1);
    at_cyc(e + 1 + 2 * 64);
    check("a5_bit1_first", {31'd0, tx}, 32'd0);
    at_cyc(e + F);
    check("a5_busy_last", {31'd0, busy}, 32'd1);
    check("a5_stop_level", {31'd0, tx}, 32'd1);
    at_cyc(e + F + 1);
    check("a5_busy_end", {31'd0, busy}, 32'd0);
    check("a5_done_pulse", {31'd0, done}, 32'd1);
    at_cyc(e + F + 2);
    check("a5_done_single", {31'd0, done}, 32'd0);

    // 0x00 then 0xFF, second start held in the done cycle.
    send(8'h00, e);
    at_cyc(e + F + 1);
    check("b2b_done_cycle", {31'd0, done}, 32'd1);
    send(8'hFF, e2);
    at_cyc(e + F + 2);
    check("b2b_no_gap", {31'd0, tx}, 32'd0);
    wait_idle();

    // Starts while busy must be ignored.
    send(8'hC3, e);
    at_cyc(e + 100);
    start = 1'b1; data = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    at_cyc(e + 600);
    start = 1'b1; data = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    at_cyc(e + F + 50);
    check("ignore_no_queue", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-frame, start at release ignored, then a clean 0x5A.
    send(8'h81, e);
    at_cyc(e + 300);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    data  = 8'hEE;
    @(negedge clk);
    start = 1'b0;
    check("release_start_ignored", {31'd0, busy}, 32'd0);
    send(8'h5A, e);
    wait_idle();

    // Sixteen random bytes through the reference receiver.
    @(negedge clk);
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) begin
      send(8'($urandom_range(0, 255)), e);
    end
    wait_idle();
    @(negedge clk);
    check("sweep_done_count", done_cnt - d0, 16);

    // SB_TICK=32: 128-cycle stop bit, done at E+705.
    start32 = 1'b1;
    data32  = 8'h69;
    e       = cyc;
    @(negedge clk);
    start32 = 1'b0;
    data32  = 8'h00;
    check("sb32_tx_first", {31'd0, tx32}, 32'd0);
    at_cyc(e + 576);
    check("sb32_bit7_last", {31'd0, tx32}, 32'd0);
    at_cyc(e + 577);
    check("sb32_stop_first", {31'd0, tx32}, 32'd1);
    at_cyc(e + 704);
    check("sb32_busy_last", {31'd0, busy32}, 32'd1);
    check("sb32_done_early", {31'd0, done32}, 32'd0);
    at_cyc(e + 705);
    check("sb32_done_pulse", {31'd0, done32}, 32'd1);
    check("sb32_busy_end", {31'd0, busy32}, 32'd0);
    at_cyc(e + 706);
    check("sb32_done_single", {31'd0, done32}, 32'd0);

    repeat (10) @(negedge clk);
    check("frames_outstanding", exp_q.size(), 0);
    check("dones_outstanding", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
